// File: rtl/sar_link_pkg.sv
// sar_link_pkg
//   Shared constants and types for the SAR transmit link.
//   - UART_FRAME_BITS : bits per UART character (start + 8 data + stop)
//   - FSM_* encodings and frame_state_e for the frame sequencer
//   - DEFAULT_HEADER  : first byte of every frame
//   - bytes_for_width : number of whole bytes needed to carry a result
package sar_link_pkg;

    localparam int UART_FRAME_BITS = 10;

    localparam logic [1:0] FSM_IDLE = 2'd0;
    localparam logic [1:0] FSM_LOAD = 2'd1;
    localparam logic [1:0] FSM_SEND = 2'd2;
    localparam logic [1:0] FSM_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = FSM_IDLE,
        ST_LOAD = FSM_LOAD,
        ST_SEND = FSM_SEND,
        ST_DONE = FSM_DONE
    } frame_state_e;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic int bytes_for_width(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// uart_tx_ser
//   8N1 byte serializer. A load pulse captures data_i and drives the start
//   bit on the next edge; every following tick_baud_i advances one bit
//   (d0..d7, then stop). done_o pulses for one cycle on the clock after the
//   tick that closes the stop bit. A tick coinciding with the load cycle is
//   not counted. load_i is ignored while a character is in flight.
// Ports
//   clk_i        in   system clock
//   rst_ni       in   synchronous reset, active-low
//   tick_baud_i  in   one-cycle pulse per bit period
//   load_i       in   start a character with data_i
//   data_i[7:0]  in   character to send
//   tx_o         out  serial line, idles high
//   done_o       out  one-cycle pulse, character complete
//   busy_o       out  character in flight
module uart_tx_ser
    import sar_link_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_baud_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o,
    output logic       busy_o
);

    localparam logic [3:0] LastBit = 4'(UART_FRAME_BITS - 1);

    // Stop bit sits above the data, and ones shift in from the top, so the
    // line is already high once the data bits have been shifted out.
    logic [8:0] shreg_q;
    logic [3:0] bit_cnt_q;
    logic       active_q;
    logic       tx_q;
    logic       done_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            active_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_i && !active_q) begin
                shreg_q   <= {1'b1, data_i};
                bit_cnt_q <= '0;
                active_q  <= 1'b1;
                tx_q      <= 1'b0;
            end else if (active_q && tick_baud_i) begin
                tx_q    <= shreg_q[0];
                shreg_q <= {1'b1, shreg_q[8:1]};
                if (bit_cnt_q == LastBit) begin
                    // This tick ends the stop bit.
                    bit_cnt_q <= '0;
                    active_q  <= 1'b0;
                    done_q    <= 1'b1;
                    tx_q      <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end
        end
    end

    assign tx_o   = tx_q;
    assign done_o = done_q;
    assign busy_o = active_q;

endmodule

// File: rtl/sar_frame_tx.sv
// sar_frame_tx
//   Transmit end of the acquisition link. start_tx_i latches sar_data_i and
//   sends a UART frame: header, data bytes MS byte first (zero-extended to
//   whole bytes), then optionally an XOR checksum of header and data bytes.
//   eot_o pulses once the last stop bit has ended.
//   Handshake: start_tx_i is accepted only in IDLE (busy_o low); it is a
//   single-cycle request with no queueing. busy_o is high from the cycle
//   after acceptance through the eot_o cycle inclusive.
// Configuration
//   SAR_FRAME_TX_CHECKSUM_EN : when defined, append the checksum byte.
// Parameters
//   DataWidth  SAR result width (1..32)
//   Header     first byte of every frame
// Ports
//   clk_i        in   system clock
//   rst_ni       in   synchronous reset, active-low (aborts a frame, no eot_o)
//   tick_baud_i  in   one-cycle pulse per bit period
//   start_tx_i   in   request to send a frame
//   sar_data_i   in   SAR result, sampled on accepted start_tx_i
//   tx_o         out  UART line, 8N1, idles high
//   busy_o       out  frame in progress
//   eot_o        out  one-cycle pulse, frame complete
module sar_frame_tx
    import sar_link_pkg::*;
#(
    parameter int         DataWidth = 12,
    parameter logic [7:0] Header    = DEFAULT_HEADER
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_baud_i,
    input  logic                 start_tx_i,
    input  logic [DataWidth-1:0] sar_data_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 eot_o
);

    localparam int NB = bytes_for_width(DataWidth);
`ifdef SAR_FRAME_TX_CHECKSUM_EN
    localparam int NFR = NB + 2;
`else
    localparam int NFR = NB + 1;
`endif
    localparam int BW = $clog2(NFR + 1);

    frame_state_e         state_q, state_d;
    logic [BW-1:0]        byte_idx_q, byte_idx_d;
    logic [DataWidth-1:0] data_q;
    logic [NB*8-1:0]      data_ext;
    logic [7:0]           cur_byte;
    logic                 ser_load;
    logic                 ser_done;
    logic                 ser_busy;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            if (state_q == ST_IDLE && start_tx_i) begin
                data_q <= sar_data_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        ser_load   = 1'b0;
        eot_o      = 1'b0;
        busy_o     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_tx_i) begin
                    byte_idx_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!ser_busy) begin
                    ser_load = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_done) begin
                    if (byte_idx_q == BW'(NFR - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                eot_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_ext = (NB*8)'(data_q);

`ifdef SAR_FRAME_TX_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = Header;
        for (int i = 0; i < NB; i++) begin
            checksum = checksum ^ data_ext[i*8 +: 8];
        end
    end
`endif

    // byte_idx 0 is the header, 1..NB walk the data from the MS byte down,
    // and the slot after the data holds the checksum when enabled.
    always_comb begin
        cur_byte = Header;
        for (int i = 0; i < NB; i++) begin
            if (byte_idx_q == BW'(i + 1)) begin
                cur_byte = data_ext[(NB-1-i)*8 +: 8];
            end
        end
`ifdef SAR_FRAME_TX_CHECKSUM_EN
        if (byte_idx_q == BW'(NFR - 1)) begin
            cur_byte = checksum;
        end
`endif
    end

    uart_tx_ser u_ser (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tick_baud_i (tick_baud_i),
        .load_i      (ser_load),
        .data_i      (cur_byte),
        .tx_o        (tx_o),
        .done_o      (ser_done),
        .busy_o      (ser_busy)
    );

endmodule

// File: tb/tb_sar_frame_tx.sv
// tb_sar_frame_tx
//   Bench for sar_frame_tx (DataWidth=12). Expected bytes come from a frame
//   model built from the header, the data value and the XOR checksum; a
//   line decoder recovers bytes from tx_o using the baud ticks and compares
//   them against the expected queue. Honours SAR_FRAME_TX_CHECKSUM_EN.
module tb_sar_frame_tx;

    localparam int         DW  = 12;
    localparam int         NB  = (DW + 7) / 8;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          tick_baud_i = 1'b0;
    logic          start_tx_i = 1'b0;
    logic [DW-1:0] sar_data_i = '0;
    logic          tx_o;
    logic          busy_o;
    logic          eot_o;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    sar_frame_tx #(.DataWidth(DW), .Header(HDR)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tick_baud_i (tick_baud_i),
        .start_tx_i  (start_tx_i),
        .sar_data_i  (sar_data_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .eot_o       (eot_o)
    );

    // ---------------- scoreboard ----------------
    int         vectors = 0;
    int         miscompares = 0;
    int         frames_exp = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame model: header, data bytes MS first, optional XOR checksum.
    task automatic push_frame(input logic [DW-1:0] d);
        logic [31:0] v;
        logic [7:0]  b;
`ifdef SAR_FRAME_TX_CHECKSUM_EN
        logic [7:0]  cs;
        cs = HDR;
`endif
        v = 32'(d);
        exp_q.push_back(HDR);
        for (int i = NB - 1; i >= 0; i--) begin
            b = 8'(v >> (8 * i));
            exp_q.push_back(b);
`ifdef SAR_FRAME_TX_CHECKSUM_EN
            cs = cs ^ b;
`endif
        end
`ifdef SAR_FRAME_TX_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    // ---------------- baud tick generator ----------------
    int tick_period = 3;
    bit tick_cont = 1'b0;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk_i);
            if (tick_cont) begin
                tick_baud_i = 1'b1;
            end else if (cnt <= 0) begin
                tick_baud_i = 1'b1;
                cnt = tick_period - 1;
            end else begin
                tick_baud_i = 1'b0;
                cnt--;
            end
        end
    end

    // ---------------- line decoder / eot monitor ----------------
    logic       tick_at_edge = 1'b0;
    logic       rst_at_edge = 1'b0;
    bit         mon_in_frame = 1'b0;
    int         mon_nbit = 0;
    int         mon_bytes = 0;
    logic [7:0] mon_sh = '0;
    int         eot_cnt = 0;
    logic       prev_eot = 1'b0;

    always @(posedge clk_i) begin
        tick_at_edge <= tick_baud_i;
        rst_at_edge  <= rst_ni;
    end

    always @(negedge clk_i) begin
        if (!rst_at_edge) begin
            mon_in_frame = 1'b0;
            mon_bytes    = 0;
        end else if (!mon_in_frame) begin
            if (tx_o === 1'b0) begin
                mon_in_frame = 1'b1;
                mon_nbit     = 0;
            end
        end else if (tick_at_edge) begin
            mon_nbit++;
            if (mon_nbit <= 8) begin
                mon_sh[mon_nbit-1] = tx_o;
            end else begin
                check("stop_bit", 32'(tx_o), 32'd1);
                if (exp_q.size() == 0) check("unexpected_byte", 32'(exp_q.size()), 32'd1);
                else check("frame_byte", 32'(mon_sh), 32'(exp_q.pop_front()));
                mon_bytes++;
                mon_in_frame = 1'b0;
            end
        end
        if (eot_o === 1'b1) begin
            eot_cnt++;
            check("eot_busy", 32'(busy_o), 32'd1);
            check("eot_width", 32'(prev_eot), 32'd0);
            mon_bytes = 0;
        end
        prev_eot = eot_o;
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [DW-1:0] d);
        @(negedge clk_i);
        sar_data_i = d;
        start_tx_i = 1'b1;
        push_frame(d);
        @(negedge clk_i);
        start_tx_i = 1'b0;
        // The latched value must be sent, not the live input.
        sar_data_i = DW'($urandom);
    endtask

    // Returns at the negedge of the eot_o cycle.
    task automatic wait_eot();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (eot_o === 1'b1) break;
        end
        check("eot_seen", 32'(k < 2000), 32'd1);
    endtask

    task automatic finish_frame();
        wait_eot();
        @(negedge clk_i);
        check("busy_fall", 32'(busy_o), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         e0;
        int         k;
        logic [DW-1:0] d;

        repeat (3) @(negedge clk_i);
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_eot", 32'(eot_o), 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Fixed pattern 12'hABC.
        send_frame(12'hABC);
        frames_exp++;
        finish_frame();

        // A second start mid-frame is ignored.
        e0 = eot_cnt;
        send_frame(DW'($urandom));
        frames_exp++;
        repeat (25) @(negedge clk_i);
        check("busy_mid", 32'(busy_o), 32'd1);
        sar_data_i = 12'h123;
        start_tx_i = 1'b1;
        @(negedge clk_i);
        start_tx_i = 1'b0;
        finish_frame();
        repeat (60) @(negedge clk_i);
        check("one_eot", 32'(eot_cnt - e0), 32'd1);
        check("idle_after", 32'(busy_o), 32'd0);

        // Start on the eot cycle is ignored; start the next cycle is taken.
        send_frame(DW'($urandom));
        frames_exp++;
        wait_eot();
        d = DW'($urandom);
        sar_data_i = d;
        start_tx_i = 1'b1;
        @(negedge clk_i);
        check("done_start_ignored", 32'(busy_o), 32'd0);
        push_frame(d);
        frames_exp++;
        @(negedge clk_i);
        start_tx_i = 1'b0;
        sar_data_i = DW'($urandom);
        check("busy_rise", 32'(busy_o), 32'd1);
        check("tx_gap", 32'(tx_o), 32'd1);
        @(negedge clk_i);
        check("tx_fall_lat", 32'(tx_o), 32'd0);
        finish_frame();

        // Reset during the 2nd data bit of byte 2.
        send_frame(DW'($urandom));
        for (k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (mon_bytes == 1 && mon_in_frame && mon_nbit == 2) break;
        end
        check("abort_point", 32'(k < 2000), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("abort_tx", 32'(tx_o), 32'd1);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_eot", 32'(eot_o), 32'd0);
        exp_q.delete();
        e0 = eot_cnt;
        repeat (50) @(negedge clk_i);
        check("abort_no_eot", 32'(eot_cnt - e0), 32'd0);
        send_frame(DW'($urandom));
        frames_exp++;
        finish_frame();

        // Tick held high: one cycle per bit.
        tick_cont = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_frame(DW'($urandom));
            frames_exp++;
            finish_frame();
        end
        tick_cont = 1'b0;

        // Random data with random baud periods.
        for (int i = 0; i < 4; i++) begin
            tick_period = $urandom_range(1, 5);
            repeat ($urandom_range(1, 8)) @(negedge clk_i);
            send_frame(DW'($urandom));
            frames_exp++;
            finish_frame();
        end

        repeat (20) @(negedge clk_i);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(eot_cnt), 32'(frames_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
